regfile_write_arbiter: RTL

//  Owns the single write port of the 8x16 SLC-3 register file. Arbitrates it between the

---
 rtl/regfile_write_arbiter.sv | 77 +++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owns the register file write port, zero-fills it after reset or clear, then arbitrates WB and DBG writers
// Ports:
//   Clk, Reset_n               clock, asynchronous active-low reset
//   clear_req                  restart the fill sequence (honoured in RUN only)
//   wb_valid/addr/data/ready   write-back requester handshake
//   dbg_valid/addr/data/ready  debug requester handshake
//   rf_we/rf_waddr/rf_wdata    registered register file write port
//   init_done                  high once the fill sequence has completed
module regfile_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int STARVE_LIMIT = 4,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              clear_req,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,
    input  logic              dbg_valid,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              dbg_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              init_done
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t            state, state_nx;
    logic [ADDR_W-1:0] clr_cnt;
    logic [SW-1:0]     starve_cnt;
    logic              clr_last, dbg_win, grant_ok;
    always_comb begin
        clr_last  = &clr_cnt;
        grant_ok  = state == RUN && !clear_req;
        // DBG only beats a concurrent WB request once WB has starved it long enough
        dbg_win   = dbg_valid && (!wb_valid || starve_cnt == SW'(STARVE_LIMIT));
        wb_ready  = grant_ok && wb_valid && !dbg_win;
        dbg_ready = grant_ok && dbg_win;
        state_nx  = state == CLEAR ? (clr_last ? RUN : CLEAR) : (clear_req ? CLEAR : RUN);
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            starve_cnt <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            init_done  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == CLEAR) begin
                rf_we     <= 1'b1;
                rf_waddr  <= clr_cnt;
                rf_wdata  <= INIT_VALUE;
                clr_cnt   <= clr_cnt + ADDR_W'(1);
                init_done <= clr_last;
            end else if (clear_req) begin
                rf_we      <= 1'b0;
                init_done  <= 1'b0;
                clr_cnt    <= '0;
                starve_cnt <= '0;
            end else begin
                rf_we    <= wb_ready || dbg_ready;
                rf_waddr <= dbg_ready ? dbg_addr : wb_ready ? wb_addr : rf_waddr;
                rf_wdata <= dbg_ready ? dbg_data : wb_ready ? wb_data : rf_wdata;
                starve_cnt <= (!dbg_valid || dbg_ready) ? '0 :
                              (wb_ready && starve_cnt != SW'(STARVE_LIMIT)) ? starve_cnt + SW'(1) : starve_cnt;
            end
        end
    end
endmodule
